// File: rtl/p_alu_defs.sv
// P-extension ALU shared definitions: op codes, multiplier FSM states, lane counts.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package p_alu_defs;

    // Decoded 5-bit ALU control codes for the packed multiply ops.
    localparam logic [4:0] ALU_SMUL16 = 5'b11100;
    localparam logic [4:0] ALU_UMUL16 = 5'b11101;
    localparam logic [4:0] ALU_SMUL8  = 5'b11110;
    localparam logic [4:0] ALU_UMUL8  = 5'b11111;

    // alu_control[4:2] value shared by all four multiply ops.
    localparam logic [2:0] ALU_MUL_CLASS = 3'b111;

    // Multiplier sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Index of the final lane in each lane mode.
    localparam logic [1:0] LAST_LANE_16 = 2'd1;
    localparam logic [1:0] LAST_LANE_8  = 2'd3;

    // Widen a 16-bit lane (or its low byte in 8-bit mode) to a 17-bit signed
    // operand. The extra bit lets unsigned values ride on a signed multiplier.
    function automatic logic signed [16:0] lane_extend(
        input logic [15:0] v,
        input logic        is_8bit,
        input logic        is_unsigned
    );
        logic sgn;
        if (is_8bit) begin
            sgn = is_unsigned ? 1'b0 : v[7];
            lane_extend = {{9{sgn}}, v[7:0]};
        end else begin
            sgn = is_unsigned ? 1'b0 : v[15];
            lane_extend = {sgn, v};
        end
    endfunction

endpackage

// File: rtl/p_mul_lane.sv
// One SIMD multiply lane: sign/zero-extend front end feeding a 17x17 signed multiply.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: a, b (16-bit lane operands; only [7:0] used in 8-bit mode), is_8bit,
//        is_unsigned, prod (32-bit product; low 16 bits hold the 8-bit result).
module p_mul_lane
    import p_alu_defs::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        is_8bit,
    input  logic        is_unsigned,
    output logic [31:0] prod
);

    logic signed [16:0] a_ext;
    logic signed [16:0] b_ext;
    logic signed [33:0] full;
    logic               unused_prod_hi;

    assign a_ext = lane_extend(a, is_8bit, is_unsigned);
    assign b_ext = lane_extend(b, is_8bit, is_unsigned);
    assign full  = a_ext * b_ext;

    // A 2N-bit product of N-bit operands is exact, so the top bits carry no information.
    assign prod           = full[31:0];
    assign unused_prod_hi = ^full[33:32];

endmodule

// File: rtl/p_mul_unit.sv
// Execute-stage SIMD multiplier for SMUL16/UMUL16/SMUL8/UMUL8 (64-bit packed result).
// Latency: done_o 3 cycles (16-bit) / 5 cycles (8-bit) after accept; 2 cycles with P_MUL_PARALLEL_EN.
// Backpressure: stall_o holds the pipeline from accept through the last RUN cycle; drops in DONE.
// Ports: clk, reset (sync, active-high), start_i, alu_control_i, src_a_i, src_b_i,
//        flush_i (kills in-flight op), busy_o, stall_o, done_o, result_o.
// Build option: P_MUL_PARALLEL_EN instantiates four lane multipliers and finishes in one RUN cycle.
module p_mul_unit
    import p_alu_defs::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [OPW-1:0]    alu_control_i,
    input  logic [XLEN-1:0]   src_a_i,
    input  logic [XLEN-1:0]   src_b_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] result_o
);

`ifdef P_MUL_PARALLEL_EN
    localparam int N_LANES = 4;
`else
    localparam int N_LANES = 1;
`endif

    mul_state_t        state;
    mul_state_t        state_nxt;
    logic [1:0]        lane_cnt;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              mode_8;
    logic              mode_uns;
    logic [2*XLEN-1:0] result_q;
    logic              accept;
    logic              last_lane;

    logic [15:0] lane_a    [N_LANES];
    logic [15:0] lane_b    [N_LANES];
    logic [31:0] lane_prod [N_LANES];

    // Reset wins over start, and a flush in the same cycle kills the request.
    assign accept = (state == ST_IDLE) && start_i && !flush_i && !reset &&
                    (alu_control_i[4:2] == ALU_MUL_CLASS);

`ifdef P_MUL_PARALLEL_EN
    assign last_lane = 1'b1;
`else
    assign last_lane = (lane_cnt == (mode_8 ? LAST_LANE_8 : LAST_LANE_16));
`endif

    // ---------------- lane operand steering and multipliers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
`ifdef P_MUL_PARALLEL_EN
            if (gi < 2) begin : g_wide
                assign lane_a[gi] = mode_8 ? {8'h00, op_a[8*gi +: 8]} : op_a[16*gi +: 16];
                assign lane_b[gi] = mode_8 ? {8'h00, op_b[8*gi +: 8]} : op_b[16*gi +: 16];
            end else begin : g_narrow
                // Upper two multipliers only serve 8-bit mode.
                assign lane_a[gi] = {8'h00, op_a[8*gi +: 8]};
                assign lane_b[gi] = {8'h00, op_b[8*gi +: 8]};
            end
`else
            // The single shared multiplier walks the lanes under lane_cnt.
            assign lane_a[gi] = mode_8 ? {8'h00, op_a[{lane_cnt, 3'b000} +: 8]}
                                       : op_a[{lane_cnt[0], 4'b0000} +: 16];
            assign lane_b[gi] = mode_8 ? {8'h00, op_b[{lane_cnt, 3'b000} +: 8]}
                                       : op_b[{lane_cnt[0], 4'b0000} +: 16];
`endif
            p_mul_lane u_lane (
                .a           (lane_a[gi]),
                .b           (lane_b[gi]),
                .is_8bit     (mode_8),
                .is_unsigned (mode_uns),
                .prod        (lane_prod[gi])
            );
        end
    endgenerate

`ifdef P_MUL_PARALLEL_EN
    logic [2*XLEN-1:0] par_result;
    logic              unused_par_hi;
    assign par_result = mode_8 ? {lane_prod[3][15:0], lane_prod[2][15:0],
                                  lane_prod[1][15:0], lane_prod[0][15:0]}
                               : {lane_prod[1], lane_prod[0]};
    assign unused_par_hi = ^{lane_prod[3][31:16], lane_prod[2][31:16]};
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_o = accept;
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o  = 1'b1;
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else if (last_lane) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stall already released so execute consumes result_o this cycle.
                done_o    = !flush_i;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            mode_8   <= 1'b0;
            mode_uns <= 1'b0;
            lane_cnt <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_a     <= src_a_i;
            op_b     <= src_b_i;
            mode_8   <= alu_control_i[1];
            mode_uns <= alu_control_i[0];
            lane_cnt <= '0;
            // Clear so stale lanes of a previous op never show through.
            result_q <= '0;
        end else if ((state != ST_IDLE) && flush_i) begin
            lane_cnt <= '0;
            result_q <= '0;
        end else if (state == ST_RUN) begin
`ifdef P_MUL_PARALLEL_EN
            result_q <= par_result;
`else
            if (mode_8) begin
                result_q[{lane_cnt, 4'b0000} +: 16] <= lane_prod[0][15:0];
            end else begin
                result_q[{lane_cnt[0], 5'b00000} +: 32] <= lane_prod[0];
            end
`endif
            lane_cnt <= lane_cnt + 2'd1;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_p_mul_unit.sv
// Testbench for p_mul_unit: directed vectors plus randomized traffic against a
// lane-arithmetic reference model; every cycle the outputs are compared.
// Honors P_MUL_PARALLEL_EN for the expected latency.
module tb_p_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [4:0]  alu_control_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [63:0] result_o;

    p_mul_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .alu_control_i (alu_control_i),
        .src_a_i       (src_a_i),
        .src_b_i       (src_b_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .result_o      (result_o)
    );

    always #5 clk = ~clk;

`ifdef P_MUL_PARALLEL_EN
    localparam int LAT16 = 2;
    localparam int LAT8  = 2;
`else
    localparam int LAT16 = 3;
    localparam int LAT8  = 5;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: op in flight for cycle m_k of m_lat, final product m_final.
    bit          m_active = 1'b0;
    int          m_k      = 0;
    int          m_lat    = 0;
    int          m_w      = 16;
    logic [63:0] m_final  = '0;
    logic [63:0] m_hold   = '0;

    // Output snapshot taken by the per-cycle compare.
    bit          last_done;
    bit          last_stall;
    bit          last_busy;
    logic [63:0] last_result;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packed lane products from plain integer arithmetic.
    function automatic logic [63:0] ref_mul(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int          w;
        int          n;
        longint      va;
        longint      vb;
        longint      p;
        logic [63:0] r;
        w = op[1] ? 8 : 16;
        n = op[1] ? 4 : 2;
        r = '0;
        for (int i = 0; i < n; i++) begin
            va = longint'((a >> (w * i)) & ((32'd1 << w) - 32'd1));
            vb = longint'((b >> (w * i)) & ((32'd1 << w) - 32'd1));
            if (!op[0]) begin
                if (va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
                if (vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
            end
            p = va * vb;
            r = r | ((64'(p) & ((64'd1 << (2 * w)) - 64'd1)) << (2 * w * i));
        end
        return r;
    endfunction

    function automatic logic [63:0] low_mask(input int nbits);
        if (nbits >= 64) return '1;
        return (64'd1 << nbits) - 64'd1;
    endfunction

    function automatic bit is_mul_start();
        return start_i && (alu_control_i[4:2] == 3'b111) && !flush_i;
    endfunction

    task automatic check_cycle();
        logic        e_stall;
        logic        e_busy;
        logic        e_done;
        logic [63:0] e_res;
        last_done   = done_o;
        last_stall  = stall_o;
        last_busy   = busy_o;
        last_result = result_o;
        if (reset) return;
        if (!m_active) begin
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_stall = is_mul_start();
            e_res   = m_hold;
        end else if (m_k < m_lat) begin
            e_busy  = 1'b1;
            e_done  = 1'b0;
            e_stall = 1'b1;
            // Lanes written so far: one per completed RUN cycle (all at once when parallel).
            e_res   = m_final & low_mask((m_k - 1) * 2 * m_w);
        end else begin
            e_busy  = 1'b0;
            e_done  = !flush_i;
            e_stall = 1'b0;
            e_res   = m_final;
        end
        chk("stall", 64'(stall_o), 64'(e_stall));
        chk("busy", 64'(busy_o), 64'(e_busy));
        chk("done", 64'(done_o), 64'(e_done));
        chk("result", result_o, e_res);
    endtask

    task automatic advance();
        if (reset) begin
            m_active = 1'b0;
            m_hold   = '0;
        end else if (!m_active) begin
            if (is_mul_start()) begin
                m_active = 1'b1;
                m_k      = 1;
                m_lat    = alu_control_i[1] ? LAT8 : LAT16;
                m_w      = alu_control_i[1] ? 8 : 16;
                m_final  = ref_mul(alu_control_i, src_a_i, src_b_i);
            end
        end else if (flush_i) begin
            m_active = 1'b0;
            m_hold   = '0;
        end else if (m_k < m_lat) begin
            m_k++;
        end else begin
            m_active = 1'b0;
            m_hold   = m_final;
        end
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        #1;
        check_cycle();
        advance();
        @(negedge clk);
    endtask

    task automatic run_directed(input string name, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        bit seen;
        seen          = 1'b0;
        start_i       = 1'b1;
        alu_control_i = op;
        src_a_i       = a;
        src_b_i       = b;
        flush_i       = 1'b0;
        cycle();
        start_i = 1'b0;
        src_a_i = $urandom;
        src_b_i = $urandom;
        for (int n = 1; n <= 8 && !seen; n++) begin
            cycle();
            if (last_done) begin
                seen = 1'b1;
                chk({name, " latency"}, 64'(n), 64'(exp_lat));
                chk({name, " result"}, last_result, exp);
            end
        end
        chk({name, " done pulse"}, 64'(seen), 64'd1);
    endtask

    logic [31:0] edge_vals [6] = '{32'h80808080, 32'h7F7F7F7F, 32'hFFFFFFFF,
                                   32'h00000000, 32'h80007FFF, 32'h01FF7F80};

    initial begin
        reset         = 1'b1;
        start_i       = 1'b0;
        flush_i       = 1'b0;
        alu_control_i = '0;
        src_a_i       = '0;
        src_b_i       = '0;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;

        chk("reset result", result_o, 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset done", 64'(done_o), 64'd0);
        chk("reset stall", 64'(stall_o), 64'd0);

        run_directed("smul16", 5'b11100, 32'hFFFF0002, 32'h00030004, 64'hFFFFFFFD_00000008, LAT16);
        run_directed("umul16", 5'b11101, 32'hFFFF0002, 32'h00030004, 64'h0002FFFD_00000008, LAT16);
        cycle();
        chk("hold after done", result_o, 64'h0002FFFD_00000008);
        run_directed("smul8", 5'b11110, 32'h807FFF02, 32'h02020203, 64'hFF00_00FE_FFFE_0006, LAT8);
        run_directed("umul8", 5'b11111, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFE01_FE01_FE01_FE01, LAT8);

        // Flush on the second cycle after accept.
        start_i       = 1'b1;
        alu_control_i = 5'b11110;
        src_a_i       = 32'h807FFF02;
        src_b_i       = 32'h02020203;
        cycle();
        start_i = 1'b0;
        cycle();
        flush_i = 1'b1;
        cycle();
        chk("flush done", 64'(last_done), 64'd0);
        flush_i = 1'b0;
        chk("flush result", result_o, 64'd0);
        chk("flush busy", 64'(busy_o), 64'd0);
        run_directed("after flush", 5'b11101, 32'hFFFF0002, 32'h00030004,
                     64'h0002FFFD_00000008, LAT16);

        // Non-multiply op must be ignored.
        start_i       = 1'b1;
        alu_control_i = 5'b01010;
        cycle();
        chk("bad op stall", 64'(last_stall), 64'd0);
        start_i = 1'b0;
        cycle();
        chk("bad op busy", 64'(last_busy), 64'd0);

        // Start held high while a MUL is being accepted, then flushed in IDLE: not accepted.
        start_i       = 1'b1;
        alu_control_i = 5'b11100;
        flush_i       = 1'b1;
        cycle();
        chk("flush beats start", 64'(last_stall), 64'd0);
        start_i = 1'b0;
        flush_i = 1'b0;
        cycle();

        // Reset in the middle of RUN.
        start_i       = 1'b1;
        alu_control_i = 5'b11111;
        src_a_i       = 32'hFFFFFFFF;
        src_b_i       = 32'hFFFFFFFF;
        cycle();
        start_i = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid-run reset busy", 64'(busy_o), 64'd0);
        chk("mid-run reset done", 64'(done_o), 64'd0);
        chk("mid-run reset stall", 64'(stall_o), 64'd0);
        chk("mid-run reset result", result_o, 64'd0);

        // Randomized traffic.
        for (int it = 0; it < 600; it++) begin
            reset   = ($urandom_range(99) == 0);
            start_i = ($urandom_range(2) != 0);
            flush_i = ($urandom_range(19) == 0);
            if ($urandom_range(9) < 8) alu_control_i = {3'b111, 2'($urandom_range(3))};
            else alu_control_i = 5'($urandom);
            if ($urandom_range(3) == 0) begin
                src_a_i = edge_vals[$urandom_range(5)];
                src_b_i = edge_vals[$urandom_range(5)];
            end else begin
                src_a_i = $urandom;
                src_b_i = $urandom;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
